// File: rtl/board_pkg.sv
// Shared types and constants for the board reset sequencer and button conditioner.
package board_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } reset_state_t;

  localparam int MS_PER_S = 1000;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-based debounce counter, debounced level
// and one-cycle press/release pulses. DEBOUNCE_MS = 0 gives a plain register stage.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic tick_i,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o
);

  logic [1:0] sync;
  logic       pressed;

  // Synchroniser idles at the raw released level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync <= {2{ACTIVE_LOW}};
    else            sync <= {sync[0], btn_i};
  end

  assign pressed = sync[1] ^ ACTIVE_LOW;

  if (DEBOUNCE_MS == 0) begin : g_direct
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        btn_o     <= 1'b0;
        press_o   <= 1'b0;
        release_o <= 1'b0;
      end else begin
        btn_o     <= pressed;
        press_o   <= pressed & ~btn_o;
        release_o <= ~pressed & btn_o;
      end
    end
  end else begin : g_debounce
    localparam int CW = cnt_width(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_MS);

    logic [CW-1:0] cnt;

    // The level must survive DEBOUNCE_MS full ticks before the next tick commits it.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt       <= '0;
        btn_o     <= 1'b0;
        press_o   <= 1'b0;
        release_o <= 1'b0;
      end else begin
        press_o   <= 1'b0;
        release_o <= 1'b0;
        if (pressed == btn_o) begin
          cnt <= '0;
        end else if (tick_i) begin
          if (cnt == CNT_MAX) begin
            cnt       <= '0;
            btn_o     <= pressed;
            press_o   <= pressed;
            release_o <= ~pressed;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/board_reset_ctrl.sv
// Board reset sequencer: merges PLL locks and a debounced reset button into one held reset.
// Optional RESET_CTRL_LOSS_COUNT_EN adds a saturating lock-loss counter output.
module board_reset_ctrl
  import board_pkg::*;
#(
  parameter int FREQ_HZ           = 40_000_000,
  parameter int NUM_LOCKS         = 2,
  parameter int NUM_BTNS          = 7,
  parameter int RESET_BTN         = 0,
  parameter int BTN_ACTIVE_LOW    = 1,
  parameter int DEBOUNCE_MS       = 10,
  parameter int RESET_HOLD_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_LOCKS-1:0] locks_i,
  input  logic [NUM_BTNS-1:0]  btn_i,
  output logic                 reset_o,
  output logic [NUM_BTNS-1:0]  btn_o,
  output logic [NUM_BTNS-1:0]  btn_press_o,
  output logic [NUM_BTNS-1:0]  btn_release_o,
  output reset_state_t         state_o
`ifdef RESET_CTRL_LOSS_COUNT_EN
  ,
  output logic [7:0]           lock_loss_count_o
`endif
);

  localparam int TICK_DIV = FREQ_HZ / MS_PER_S;
  localparam int PW       = cnt_width(TICK_DIV);
  localparam int HW       = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RESET_HOLD_CYCLES - 1);

  logic [NUM_LOCKS-1:0] lock_s1, lock_s2;
  logic                 all_locked;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [HW-1:0]        hold_cnt;
  reset_state_t         state;
  logic                 reset_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
    end else begin
      lock_s1 <= locks_i;
      lock_s2 <= lock_s1;
    end
  end

  assign all_locked = &lock_s2;

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  presc <= '0;
    else if (tick)   presc <= '0;
    else             presc <= presc + 1'b1;
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .ACTIVE_LOW  (BTN_ACTIVE_LOW != 0)
    ) u_btn (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .tick_i    (tick),
      .btn_i     (btn_i[i]),
      .btn_o     (btn_o[i]),
      .press_o   (btn_press_o[i]),
      .release_o (btn_release_o[i])
    );
  end

  // reset_q is a flop kept equal to (state != RUN), so reset_o never glitches on a transition.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
      reset_q  <= 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          hold_cnt <= '0;
          if (all_locked) state <= HOLD;
        end
        HOLD: begin
          if (!all_locked) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else if (btn_o[RESET_BTN]) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_MAX) begin
            state    <= RUN;
            hold_cnt <= '0;
            reset_q  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          hold_cnt <= '0;
          if (!all_locked) begin
            state   <= WAIT_LOCK;
            reset_q <= 1'b1;
          end else if (btn_o[RESET_BTN]) begin
            state   <= HOLD;
            reset_q <= 1'b1;
          end
        end
        default: begin
          state    <= WAIT_LOCK;
          hold_cnt <= '0;
          reset_q  <= 1'b1;
        end
      endcase
    end
  end

  assign reset_o = reset_q;
  assign state_o = state;

`ifdef RESET_CTRL_LOSS_COUNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      loss_cnt <= 8'd0;
    else if (state == RUN && !all_locked && loss_cnt != 8'hFF)
      loss_cnt <= loss_cnt + 8'd1;
  end

  assign lock_loss_count_o = loss_cnt;
`endif

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Scoreboard bench for board_reset_ctrl: stimulus pushes expected output events with
// edge windows, a negedge monitor pops and compares every observed output change.
module tb_board_reset_ctrl;
  import board_pkg::*;

  localparam int NL = 2;
  localparam int NB = 2;

  localparam logic [3:0] K_RST_RISE = 4'd0;
  localparam logic [3:0] K_RST_FALL = 4'd1;
  localparam logic [3:0] K_B0_RISE  = 4'd2;
  localparam logic [3:0] K_B0_FALL  = 4'd3;
  localparam logic [3:0] K_B1_RISE  = 4'd4;
  localparam logic [3:0] K_PRESS0   = 4'd6;
  localparam logic [3:0] K_REL0     = 4'd7;
  localparam logic [3:0] K_PRESS1   = 4'd8;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [NL-1:0] locks_i = 2'b11;
  logic [NB-1:0] btn_i = 2'b11;
  logic          reset_o;
  logic [NB-1:0] btn_o, btn_press_o, btn_release_o;
  reset_state_t  state_o;
`ifdef RESET_CTRL_LOSS_COUNT_EN
  logic [7:0]    lock_loss_count_o;
`endif

  board_reset_ctrl #(
    .FREQ_HZ           (4000),
    .NUM_LOCKS         (NL),
    .NUM_BTNS          (NB),
    .RESET_BTN         (0),
    .BTN_ACTIVE_LOW    (1),
    .DEBOUNCE_MS       (2),
    .RESET_HOLD_CYCLES (16)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .locks_i       (locks_i),
    .btn_i         (btn_i),
    .reset_o       (reset_o),
    .btn_o         (btn_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o),
    .state_o       (state_o)
`ifdef RESET_CTRL_LOSS_COUNT_EN
    ,
    .lock_loss_count_o (lock_loss_count_o)
`endif
  );

  // Clock and edge counter
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard: {kind, first allowed edge, last allowed edge}
  logic [35:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int last_rst_fall = 0;
  int last_b0_fall = 0;

  task automatic push_exp(input logic [3:0] k, input int lo, input int hi);
    exp_q.push_back({k, lo[15:0], hi[15:0]});
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic observe(input logic [3:0] k);
    logic [35:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected kind %0d at edge %0d, none expected", k, edge_cnt);
    end else begin
      e = exp_q.pop_front();
      if (e[35:32] != k || edge_cnt < int'(e[31:16]) || edge_cnt > int'(e[15:0])) begin
        n_err++;
        $display("FAIL event: got kind %0d at edge %0d expected kind %0d in edges %0d..%0d",
                 k, edge_cnt, e[35:32], e[31:16], e[15:0]);
      end
    end
    if (k == K_RST_FALL) last_rst_fall = edge_cnt;
    if (k == K_B0_FALL)  last_b0_fall  = edge_cnt;
  endtask

  // Monitor: every change of reset_o/btn_o and every pulse cycle is one event
  initial begin : monitor
    logic          p_rst;
    logic [NB-1:0] p_btn;
    p_rst = 1'b1;
    p_btn = '0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        p_rst = reset_o;
        p_btn = btn_o;
      end else begin
        if (reset_o !== p_rst) observe(reset_o ? K_RST_RISE : K_RST_FALL);
        for (int i = 0; i < NB; i++)
          if (btn_o[i] !== p_btn[i]) observe(btn_o[i] ? 4'(2 + 2*i) : 4'(3 + 2*i));
        for (int i = 0; i < NB; i++) begin
          if (btn_press_o[i] === 1'b1)   observe(4'(6 + 2*i));
          if (btn_release_o[i] === 1'b1) observe(4'(7 + 2*i));
        end
        p_rst = reset_o;
        p_btn = btn_o;
      end
    end
  end

  // Driver tasks (always entered and left on a negedge)
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lock_glitch(input bit expect_recover);
    int n;
    n = edge_cnt;
    locks_i = 2'b01;
    push_exp(K_RST_RISE, n + 3, n + 3);
    @(negedge clk);
    locks_i = 2'b11;
    if (expect_recover) push_exp(K_RST_FALL, n + 20, n + 20);
  endtask

  task automatic reset_btn_cycle();
    int n;
    n = edge_cnt;
    btn_i[0] = 1'b0;
    push_exp(K_B0_RISE, n + 10, n + 14);
    push_exp(K_PRESS0, n + 10, n + 14);
    push_exp(K_RST_RISE, n + 11, n + 15);
    cycles(30);
    n = edge_cnt;
    btn_i[0] = 1'b1;
    push_exp(K_B0_FALL, n + 10, n + 14);
    push_exp(K_REL0, n + 10, n + 14);
    push_exp(K_RST_FALL, n + 26, n + 30);
    cycles(40);
    check("hold_after_btn_release", last_rst_fall - last_b0_fall, 16);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reset_o"}, int'(reset_o), 1);
    check({tag, "_btn_o"}, int'(btn_o), 0);
    check({tag, "_pulses"}, int'({btn_press_o, btn_release_o}), 0);
    check({tag, "_state"}, int'(state_o), int'(WAIT_LOCK));
  endtask

  initial begin : stimulus
    int n;
    logic [35:0] e;

    // 1: power-up with locks already high
    cycles(5);
    check_reset_values("por");
`ifdef RESET_CTRL_LOSS_COUNT_EN
    check("por_loss_count", int'(lock_loss_count_o), 0);
`endif
    reset_n_i = 1'b1;
    n = edge_cnt;
    push_exp(K_RST_FALL, n + 19, n + 19);
    cycles(25);
    check("run_state", int'(state_o), int'(RUN));

    // 2: one-cycle lock glitch in RUN
    lock_glitch(1'b1);
    cycles(25);

    // 3: bouncing button 1, then a clean press
    for (int k = 0; k < 14; k++) begin
      btn_i[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
      cycles(3);
    end
    n = edge_cnt;
    btn_i[1] = 1'b0;
    push_exp(K_B1_RISE, n + 10, n + 14);
    push_exp(K_PRESS1, n + 10, n + 14);
    cycles(20);
    check("btn1_level", int'(btn_o), 2);

    // 4: reset button press and release in RUN
    reset_btn_cycle();

    // 5: asynchronous reset in the middle of HOLD (hold counter at 8)
    lock_glitch(1'b0);
    cycles(11);
    check("mid_hold_state", int'(state_o), int'(HOLD));
    check("mid_hold_btn", int'(btn_o), 2);
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_values("async");
`ifdef RESET_CTRL_LOSS_COUNT_EN
    check("async_loss_count", int'(lock_loss_count_o), 0);
`endif
    btn_i[1] = 1'b1;
    cycles(3);
    reset_n_i = 1'b1;
    n = edge_cnt;
    push_exp(K_RST_FALL, n + 19, n + 19);
    cycles(25);

`ifdef RESET_CTRL_LOSS_COUNT_EN
    // 6: lock-loss counter counts, saturates and ignores the reset button
    for (int k = 0; k < 3; k++) begin
      lock_glitch(1'b1);
      cycles(22);
    end
    check("loss_count_3", int'(lock_loss_count_o), 3);
    for (int k = 3; k < 300; k++) begin
      lock_glitch(1'b1);
      cycles(22);
    end
    check("loss_count_sat", int'(lock_loss_count_o), 255);
    reset_btn_cycle();
    check("loss_count_btn", int'(lock_loss_count_o), 255);
`endif

    // Report
    cycles(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL event_missing: kind %0d never seen, expected in edges %0d..%0d",
               e[35:32], e[31:16], e[15:0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
